// File: rtl/mem_arbiter.sv
// Arbitrates the single pipelined main-memory port between the I-side and D-side caches.
// Sequences block fills and write-through stores, tagging returned fill words with their index.
module mem_arbiter #(
  parameter int  BLK_WORDS = 8,
  localparam int IDX_W     = $clog2(BLK_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [15:0]      i_addr,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic [15:0]      fill_data,
  output logic             i_data_valid,
  output logic             d_data_valid,
  output logic [IDX_W-1:0] word_idx,
  output logic             i_done,
  output logic             d_done,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

  localparam logic [IDX_W:0]   BLK_CNT  = (IDX_W+1)'(BLK_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_WORDS - 1);

  state_t           state_reg, state_next;
  logic [15:0]      addr_reg;
  logic [15:0]      wdata_reg;
  logic             last_d_reg;
  logic [IDX_W:0]   issue_cnt_reg;
  logic [IDX_W-1:0] ret_cnt_reg;

  logic             grant_i, grant_d;
  logic             in_fill, issuing, last_ret;
  logic [15:0]      issue_addr;

  assign in_fill    = (state_reg == FILL_I) || (state_reg == FILL_D);
  assign issuing    = in_fill && (issue_cnt_reg < BLK_CNT);
  assign last_ret   = in_fill && mem_rvalid && (ret_cnt_reg == LAST_IDX);
  // Block base has its low IDX_W+1 bits cleared, so the word offset slots straight in.
  assign issue_addr = {addr_reg[15:IDX_W+1], issue_cnt_reg[IDX_W-1:0], 1'b0};
  assign fill_data  = mem_rdata;
  assign busy       = (state_reg != IDLE);

  always_comb begin
    state_next   = state_reg;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    word_idx     = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    case (state_reg)
      IDLE: begin
        // On a tie the side that did not win last time gets the port.
        if (d_req && (!i_req || !last_d_reg)) begin
          grant_d    = 1'b1;
          state_next = d_wr ? WRITE : FILL_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = FILL_I;
        end
      end
      FILL_I, FILL_D: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = issue_addr;
        end
        word_idx     = ret_cnt_reg;
        i_data_valid = (state_reg == FILL_I) && mem_rvalid;
        d_data_valid = (state_reg == FILL_D) && mem_rvalid;
        if (last_ret) begin
          i_done     = (state_reg == FILL_I);
          d_done     = (state_reg == FILL_D);
          state_next = IDLE;
        end
      end
      WRITE: begin
        mem_en     = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = addr_reg;
        mem_wdata  = wdata_reg;
        d_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= 16'h0000;
      wdata_reg     <= 16'h0000;
      last_d_reg    <= 1'b0;
      issue_cnt_reg <= '0;
      ret_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_i) begin
        addr_reg <= i_addr;
      end
      if (grant_d) begin
        addr_reg  <= d_addr;
        wdata_reg <= d_wdata;
      end
      if (grant_i || grant_d) begin
        last_d_reg    <= grant_d;
        issue_cnt_reg <= '0;
        ret_cnt_reg   <= '0;
      end else if (in_fill) begin
        if (issuing) begin
          issue_cnt_reg <= issue_cnt_reg + 1'b1;
        end
        if (mem_rvalid) begin
          ret_cnt_reg <= ret_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-latency memory model plus address/return scoreboards
// filled when requests are driven and drained as the arbiter issues and returns words.
module tb_mem_arbiter;

  localparam int BLK   = 8;
  localparam int IDX_W = 3;
  localparam int L     = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0]      i_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0;
  logic [15:0]      fill_data, mem_addr, mem_wdata, mem_rdata;
  logic             i_data_valid, d_data_valid, i_done, d_done;
  logic             mem_en, mem_wr, mem_rvalid, busy;
  logic [IDX_W-1:0] word_idx;

  logic             stray_rv = 1'b0;
  logic [15:0]      stray_d = 16'h0;

  logic [L-1:0]     pv = '0;
  logic [15:0]      pd [L] = '{default: 16'h0};

  logic [15:0]      addr_q [$];
  logic [19:0]      data_q [$];
  int               n_checks = 0;
  int               n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.BLK_WORDS(BLK)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .fill_data(fill_data), .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .word_idx(word_idx), .i_done(i_done), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
  );

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // Memory model: a read issued in cycle c returns in cycle c+L, and keeps flowing through a DUT reset.
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], mem_en & ~mem_wr};
    pd[0] <= mem_f(mem_addr);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign mem_rvalid = pv[L-1] | stray_rv;
  assign mem_rdata  = stray_rv ? stray_d : pd[L-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("both_valid", {31'd0, i_data_valid & d_data_valid}, 32'd0);
    if (mem_en && !mem_wr) begin
      if (addr_q.size() == 0) chk("issue_unexpected", {31'd0, mem_en}, 32'd0);
      else chk("mem_addr", {16'd0, mem_addr}, {16'd0, addr_q.pop_front()});
    end
    if (i_data_valid || d_data_valid) begin
      if (data_q.size() == 0) chk("return_unexpected", {30'd0, i_data_valid, d_data_valid}, 32'd0);
      else chk("return_word", {12'd0, d_data_valid, word_idx, fill_data}, {12'd0, data_q.pop_front()});
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mem_en"}, {30'd0, mem_en, mem_wr}, 32'd0);
    chk({tag, "_mem_addr"}, {mem_addr, mem_wdata}, 32'd0);
    chk({tag, "_valid"}, {30'd0, i_data_valid, d_data_valid}, 32'd0);
    chk({tag, "_done"}, {30'd0, i_done, d_done}, 32'd0);
    chk({tag, "_word_idx"}, {29'd0, word_idx}, 32'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr  = 1'b0;
    #1;
    check_idle("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    addr_q.delete();
    data_q.delete();
  endtask

  // Caller has the owner's request high in the current cycle (cycle 0); returns in the done cycle.
  task automatic run_fill(input logic own_d, input logic [15:0] addr, input int late_d_at,
                          input logic [15:0] late_addr);
    logic [15:0] base;
    logic        own_v, oth_v, own_dn, oth_dn;
    base = addr & 16'hFFF0;
    for (int k = 0; k < BLK; k++) begin
      addr_q.push_back(base + 16'(2 * k));
      data_q.push_back({own_d, 3'(k), mem_f(base + 16'(2 * k))});
    end
    for (int c = 1; c <= BLK + L; c++) begin
      tick();
      own_v  = own_d ? d_data_valid : i_data_valid;
      oth_v  = own_d ? i_data_valid : d_data_valid;
      own_dn = own_d ? d_done : i_done;
      oth_dn = own_d ? i_done : d_done;
      chk("fill_busy", {31'd0, busy}, 32'd1);
      chk("fill_mem_en", {30'd0, mem_en, mem_wr}, {30'd0, (c <= BLK), 1'b0});
      chk("fill_valid", {30'd0, own_v, oth_v}, {30'd0, (c > L), 1'b0});
      chk("fill_done", {30'd0, own_dn, oth_dn}, {30'd0, (c == BLK + L), 1'b0});
      if (c == late_d_at) begin
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = late_addr;
      end
      if (c == BLK + L) begin
        if (own_d) d_req = 1'b0;
        else i_req = 1'b0;
      end
    end
    $display("fill %s addr %h base %h complete", own_d ? "D" : "I", addr, base);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = addr;
    d_wdata = data;
    tick();
    chk("wr_mem_en", {30'd0, mem_en, mem_wr}, 32'd3);
    chk("wr_mem_addr", {16'd0, mem_addr}, {16'd0, addr});
    chk("wr_mem_wdata", {16'd0, mem_wdata}, {16'd0, data});
    chk("wr_done", {30'd0, d_done, i_done}, 32'd2);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    d_req = 1'b0;
    d_wr  = 1'b0;
    tick();
    check_idle("wr_after");
    $display("write addr %h data %h complete", addr, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_dut();

    // Stray returns while idle must be ignored.
    stray_rv = 1'b1;
    stray_d  = 16'h1234;
    tick();
    check_idle("stray");
    stray_rv = 1'b0;
    tick();
    check_idle("stray_after");

    // I fill alone.
    i_addr = 16'h1236;
    i_req  = 1'b1;
    run_fill(1'b0, 16'h1236, 0, 16'h0);
    tick();
    check_idle("i_fill_after");

    do_write(16'h4002, 16'hBEEF);

    // Tie from reset: D first, then I which was held waiting.
    reset_dut();
    i_addr = 16'h0100;
    d_addr = 16'h0208;
    i_req  = 1'b1;
    d_req  = 1'b1;
    d_wr   = 1'b0;
    run_fill(1'b1, 16'h0208, 0, 16'h0);
    tick();
    chk("tie_gap_busy", {31'd0, busy}, 32'd0);
    chk("tie_gap_mem_en", {31'd0, mem_en}, 32'd0);
    run_fill(1'b0, 16'h0100, 0, 16'h0);
    tick();
    check_idle("tie1_after");

    // After a D write, a tie goes to I, then D.
    do_write(16'h3004, 16'h1111);
    i_addr = 16'h0300;
    i_req  = 1'b1;
    d_addr = 16'h0410;
    d_req  = 1'b1;
    d_wr   = 1'b0;
    run_fill(1'b0, 16'h0300, 0, 16'h0);
    tick();
    chk("alt_gap_busy", {31'd0, busy}, 32'd0);
    run_fill(1'b1, 16'h0410, 0, 16'h0);
    tick();
    check_idle("alt_after");

    // D request arriving mid I-fill waits for IDLE.
    i_addr = 16'h5678;
    i_req  = 1'b1;
    run_fill(1'b0, 16'h5678, 3, 16'h6000);
    tick();
    chk("late_gap_busy", {31'd0, busy}, 32'd0);
    run_fill(1'b1, 16'h6000, 0, 16'h0);
    tick();
    check_idle("late_after");

    // Reset in cycle 6 of an I fill.
    i_addr = 16'h2000;
    i_req  = 1'b1;
    for (int k = 0; k < 6; k++) addr_q.push_back(16'h2000 + 16'(2 * k));
    for (int k = 0; k < 2; k++) data_q.push_back({1'b0, 3'(k), mem_f(16'h2000 + 16'(2 * k))});
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("abort_mem_en", {31'd0, mem_en}, 32'd1);
    end
    rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    check_idle("abort_now");
    for (int c = 0; c < 2; c++) begin
      tick();
      check_idle("abort_hold");
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_idle("abort_drain");
    end
    chk("abort_queues", 32'(addr_q.size() + data_q.size()), 32'd0);
    $display("fill I addr 2000 aborted by reset");
    i_req = 1'b1;
    run_fill(1'b0, 16'h2000, 0, 16'h0);
    tick();
    check_idle("final");

    chk("queues_empty", 32'(addr_q.size() + data_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single multi-cycle main memory port between the instruction-side and data-side cache controllers of the CPU. It sequences block fills (BLK_WORDS consecutive 16-bit word reads) and single-word write-through stores, and returns fill data tagged with its word index to the owning requester. It sits between the two cache FSMs and the main memory instance.

## Interface
- BLK_WORDS, 8, words per cache block; power of two, ≥2; IDX_W = log2(BLK_WORDS)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  I-side fill request (level)
- i_addr  in  16  I-side miss byte address
- d_req  in  1  D-side request (level)
- d_wr  in  1  D-side: 1 = single-word write, 0 = block fill
- d_addr  in  16  D-side byte address
- d_wdata  in  16  D-side write data
- fill_data  out  16  returned word, shared by both sides (= mem_rdata)
- i_data_valid  out  1  fill_data belongs to I-side this cycle
- d_data_valid  out  1  fill_data belongs to D-side this cycle
- word_idx  out  IDX_W  word index within block of fill_data
- i_done  out  1  one-cycle pulse, I-side transaction complete
- d_done  out  1  one-cycle pulse, D-side transaction complete
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  memory write this cycle
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rvalid  in  1  mem_rdata valid; reads are pipelined, fixed latency, one issue per cycle
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, FILL_I, FILL_D, WRITE.
- Requests sampled only in IDLE. At grant, latch address (and d_wdata) and owner.
- Arbitration in IDLE: only one requesting → grant it. Both requesting → grant the side NOT granted last (last_grant register, reset value I, so D wins first tie). last_grant updates on every grant.
- D grant: d_wr=1 → WRITE, else FILL_D. I grant → FILL_I.
- Block base = latched addr with low IDX_W+1 bits cleared. Issue k (0..BLK_WORDS-1) uses mem_addr = base + 2k, mem_en=1, mem_wr=0.
- FILL: issue counter advances one per cycle until BLK_WORDS issues made; then mem_en=0. Return counter increments on each mem_rvalid; owner's *_data_valid = mem_rvalid, word_idx = return count, fill_data = mem_rdata. On the rvalid with return count = BLK_WORDS-1, assert owner's done same cycle, next state IDLE.
- WRITE: single cycle, mem_en=1, mem_wr=1, mem_addr=latched d_addr, mem_wdata=latched d_wdata, d_done=1; next state IDLE.
- Requester contract: req held high until done; req low in the cycle following done. Arbiter never re-grants in the done cycle.
- mem_rvalid while IDLE or WRITE ignored: no data_valid, no counter change.
- Outside FILL, *_data_valid=0; word_idx=0. Outside FILL issue and WRITE, mem_en=mem_wr=0, mem_addr=mem_wdata=0.
- Reset (any time, including mid-fill): state IDLE, counters 0, last_grant=I, all outputs 0. Read returns still in flight after reset are dropped.

## Timing
- req seen high in IDLE at cycle 0 → first mem_en at cycle 1.
- Fill, memory latency L: issues cycles 1..BLK_WORDS, returns cycles 1+L..BLK_WORDS+L, done at BLK_WORDS+L; IDLE at BLK_WORDS+L+1. Back-to-back: next grant evaluated at BLK_WORDS+L+1.
- Write: grant cycle 0, mem write and d_done cycle 1, IDLE cycle 2.
- fill_data/*_data_valid/word_idx combinational from mem_rdata/mem_rvalid; all other outputs registered-state decodes.

## Test plan
- I fill alone, i_addr=0x1236, L=4, BLK_WORDS=8: mem_addr 0x1230,0x1232..0x123E on cycles 1–8; i_data_valid cycles 5–12 with word_idx 0..7; i_done cycle 12 only; d_* outputs stay 0.
- D write d_addr=0x4002, d_wdata=0xBEEF: cycle 1 mem_en=mem_wr=1, mem_addr=0x4002, mem_wdata=0xBEEF, d_done=1; busy low cycle 2.
- Simultaneous i_req and d_req (d_wr=0) from reset: D fill first; I fill granted in the cycle after d_done; then both again → I granted (alternation), then D.
- d_req rises mid I-fill: ignored until IDLE; no interleaved mem_en; I fill words unaffected.
- rst_n low at cycle 6 of a fill: all outputs 0 immediately; later mem_rvalid pulses produce no data_valid/done; fresh request after release starts at word 0.
- Stray mem_rvalid in IDLE with no requests: no outputs change, busy stays 0.
